// File: rtl/deserializer_queue_if.sv
// rtl/deserializer_queue_if.sv - serial-in / word-out bus for deserializer_queue
//
// Signals:
//   data_in, write_in         serial bit and its valid qualifier
//   dequeue_in, clear_in      pop request and synchronous flush
//   status_out                1 = serial bits accepted, 0 = stalled
//   data_out, data_valid_out  last popped word and its one-cycle pulse
//   len_out, full_out, empty_out  queue occupancy and flags
// master drives the requests (upstream/consumer side), slave is the block.
interface deserializer_queue_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int LEN_W = $clog2(DEPTH + 1);

    logic                  data_in;
    logic                  write_in;
    logic                  dequeue_in;
    logic                  clear_in;
    logic                  status_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid_out;
    logic [LEN_W-1:0]      len_out;
    logic                  full_out;
    logic                  empty_out;

    modport master (
        output data_in, write_in, dequeue_in, clear_in,
        input  status_out, data_out, data_valid_out, len_out, full_out, empty_out
    );

    modport slave (
        input  data_in, write_in, dequeue_in, clear_in,
        output status_out, data_out, data_valid_out, len_out, full_out, empty_out
    );
endinterface

// File: rtl/deserializer_queue.sv
// rtl/deserializer_queue.sv - serial-to-parallel converter feeding a circular word queue
//
// Ports:
//   clock  rising-edge clock for all state
//   reset  asynchronous active-low reset
//   bus    deserializer_queue_if.slave (serial input, pop/clear, word output, status)
// A word completing while the queue is full is parked in a pending register and
// the serial side stalls (status_out=0) until the queue has room again.
module deserializer_queue #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int MSB_FIRST  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    deserializer_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic {
        ACCEPT = 1'b0,
        STALL  = 1'b1
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [DATA_WIDTH-1:0] pend_word;
    logic [DATA_WIDTH-1:0] enq_word;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  data_valid_r;
    logic [CW-1:0]         bit_cnt;
    logic [AW-1:0]         head;
    logic [AW-1:0]         tail;
    logic [LW-1:0]         len;

    logic accept;
    logic word_done;
    logic full;
    logic empty;
    logic enq_pend;
    logic enq;
    logic deq;

    always_comb begin
        shift_next = shift_reg;
        if (MSB_FIRST != 0) begin
            shift_next = {shift_reg[DATA_WIDTH-2:0], bus.data_in};
        end else begin
            shift_next = {bus.data_in, shift_reg[DATA_WIDTH-1:1]};
        end
    end

    assign full      = (len == LW'(DEPTH));
    assign empty     = (len == '0);
    assign accept    = bus.write_in && (state == ACCEPT);
    assign word_done = accept && (bit_cnt == CW'(DATA_WIDTH - 1));
    // Only one source can enqueue per edge: a completing word is only possible
    // in ACCEPT, the pending word only in STALL. Space is judged on len before
    // the edge, so a same-edge pop never makes room (no bypass).
    assign enq_pend  = (state == STALL) && !full;
    assign enq       = (word_done && !full) || enq_pend;
    assign enq_word  = (state == STALL) ? pend_word : shift_next;
    assign deq       = bus.dequeue_in && !empty;

    always_ff @(posedge clock) begin
        if (enq && !bus.clear_in) begin
            mem[tail] <= enq_word;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ACCEPT;
            shift_reg    <= '0;
            pend_word    <= '0;
            bit_cnt      <= '0;
            head         <= '0;
            tail         <= '0;
            len          <= '0;
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
        end else if (bus.clear_in) begin
            // Partial-word bits need no flush: a fresh word overwrites every bit.
            state        <= ACCEPT;
            bit_cnt      <= '0;
            head         <= '0;
            tail         <= '0;
            len          <= '0;
            data_valid_r <= 1'b0;
        end else begin
            data_valid_r <= deq;
            if (deq) begin
                data_out_r <= mem[head];
                head       <= head + AW'(1);
            end
            if (accept) begin
                shift_reg <= shift_next;
                bit_cnt   <= word_done ? '0 : bit_cnt + CW'(1);
            end
            if (enq) begin
                tail <= tail + AW'(1);
            end
            if (word_done && full) begin
                pend_word <= shift_next;
                state     <= STALL;
            end else if (enq_pend) begin
                state <= ACCEPT;
            end
            if (enq && !deq) begin
                len <= len + LW'(1);
            end else if (!enq && deq) begin
                len <= len - LW'(1);
            end
        end
    end

    assign bus.status_out     = (state == ACCEPT);
    assign bus.data_out       = data_out_r;
    assign bus.data_valid_out = data_valid_r;
    assign bus.len_out        = len;
    assign bus.full_out       = full;
    assign bus.empty_out      = empty;
endmodule

// File: tb/tb_deserializer_queue.sv
// tb/tb_deserializer_queue.sv - directed self-checking bench for deserializer_queue
module tb_deserializer_queue;
    logic clock;
    logic reset;
    int   tests;
    int   fails;

    deserializer_queue_if #(.DATA_WIDTH(8), .DEPTH(4)) ifa ();
    deserializer_queue_if #(.DATA_WIDTH(8), .DEPTH(4)) ifb ();

    deserializer_queue #(.DATA_WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) dut_msb (
        .clock (clock),
        .reset (reset),
        .bus   (ifa)
    );

    deserializer_queue #(.DATA_WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) dut_lsb (
        .clock (clock),
        .reset (reset),
        .bus   (ifb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic w, input logic d, input logic dq, input logic clr);
        ifa.write_in = w;  ifa.data_in = d;  ifa.dequeue_in = dq;  ifa.clear_in = clr;
        ifb.write_in = w;  ifb.data_in = d;  ifb.dequeue_in = dq;  ifb.clear_in = clr;
    endtask

    // Apply inputs for one edge, then sample 1 time unit after it.
    task automatic step(input logic w, input logic d, input logic dq, input logic clr);
        set_in(w, d, dq, clr);
        @(posedge clock);
        #1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [7:0] val);
        for (int i = 7; i >= 0; i--) step(1'b1, val[i], 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] w [10];
        tests = 0;
        fails = 0;
        reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_status", 32'(ifa.status_out), 32'd1);
        check("rst_data",   32'(ifa.data_out), 32'h00);
        check("rst_valid",  32'(ifa.data_valid_out), 32'd0);
        check("rst_len",    32'(ifa.len_out), 32'd0);
        check("rst_full",   32'(ifa.full_out), 32'd0);
        check("rst_empty",  32'(ifa.empty_out), 32'd1);
        reset = 1'b1;

        // Basic word A5, zero-latency enqueue
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (8'hA5 >> (7 - i)) & 8'h01 ? 1'b1 : 1'b0, 1'b0, 1'b0);
            if (i == 6) check("basic_len_before_last", 32'(ifa.len_out), 32'd0);
        end
        check("basic_len_after_last", 32'(ifa.len_out), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("basic_data",  32'(ifa.data_out), 32'hA5);
        check("basic_valid", 32'(ifa.data_valid_out), 32'd1);
        check("basic_len0",  32'(ifa.len_out), 32'd0);
        check("basic_empty", 32'(ifa.empty_out), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("basic_valid_drop", 32'(ifa.data_valid_out), 32'd0);

        // Bit order: 1,1,0,0,0,0,0,0 -> C0 MSB-first, 03 LSB-first
        send_word(8'hC0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("order_msb", 32'(ifa.data_out), 32'hC0);
        check("order_lsb", 32'(ifb.data_out), 32'h03);
        check("order_lsb_valid", 32'(ifb.data_valid_out), 32'd1);

        // Full and stall
        send_word(8'h01);
        send_word(8'h02);
        send_word(8'h03);
        send_word(8'h04);
        check("fill_len",    32'(ifa.len_out), 32'd4);
        check("fill_full",   32'(ifa.full_out), 32'd1);
        check("fill_status", 32'(ifa.status_out), 32'd1);
        send_word(8'h05);
        check("stall_status", 32'(ifa.status_out), 32'd0);
        check("stall_len",    32'(ifa.len_out), 32'd4);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("stall_ignore_status", 32'(ifa.status_out), 32'd0);
        check("stall_ignore_len",    32'(ifa.len_out), 32'd4);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("stall_pop_data",   32'(ifa.data_out), 32'h01);
        check("stall_pop_valid",  32'(ifa.data_valid_out), 32'd1);
        check("stall_pop_len",    32'(ifa.len_out), 32'd3);
        check("stall_pop_status", 32'(ifa.status_out), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("pend_enq_len",    32'(ifa.len_out), 32'd4);
        check("pend_enq_status", 32'(ifa.status_out), 32'd1);
        check("pend_enq_full",   32'(ifa.full_out), 32'd1);
        for (int k = 2; k <= 5; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            check($sformatf("drain_%0d", k), 32'(ifa.data_out), 32'(k));
            check($sformatf("drain_len_%0d", k), 32'(ifa.len_out), 32'(5 - k));
        end
        check("drain_empty", 32'(ifa.empty_out), 32'd1);

        // Wrap with overlapped enqueue/dequeue
        for (int k = 0; k < 10; k++) w[k] = 8'(k * 23 + 3);
        send_word(w[0]);
        check("wrap_first_len", 32'(ifa.len_out), 32'd1);
        for (int k = 1; k < 10; k++) begin
            for (int i = 7; i >= 1; i--) step(1'b1, w[k][i], 1'b0, 1'b0);
            step(1'b1, w[k][0], 1'b1, 1'b0);
            check($sformatf("wrap_data_%0d", k - 1), 32'(ifa.data_out), 32'(w[k - 1]));
            check($sformatf("wrap_len_%0d", k), 32'(ifa.len_out), 32'd1);
            check($sformatf("wrap_status_%0d", k), 32'(ifa.status_out), 32'd1);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("wrap_data_9", 32'(ifa.data_out), 32'(w[9]));
        check("wrap_empty",  32'(ifa.empty_out), 32'd1);

        // Dequeue on empty, then clear discards a partial word
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("empty_pop_valid", 32'(ifa.data_valid_out), 32'd0);
        check("empty_pop_data",  32'(ifa.data_out), 32'(w[9]));
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("clear_len",    32'(ifa.len_out), 32'd0);
        check("clear_status", 32'(ifa.status_out), 32'd1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("clear_no_early_word", 32'(ifa.len_out), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("clear_word_len", 32'(ifa.len_out), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("clear_word_data", 32'(ifa.data_out), 32'hFF);

        // Asynchronous reset while stalled with a full queue
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        send_word(8'h44);
        send_word(8'h55);
        check("areset_pre_len",    32'(ifa.len_out), 32'd4);
        check("areset_pre_status", 32'(ifa.status_out), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("areset_len",    32'(ifa.len_out), 32'd0);
        check("areset_empty",  32'(ifa.empty_out), 32'd1);
        check("areset_status", 32'(ifa.status_out), 32'd1);
        check("areset_valid",  32'(ifa.data_valid_out), 32'd0);
        check("areset_data",   32'(ifa.data_out), 32'h00);
        check("areset_full",   32'(ifa.full_out), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/deserializer_queue.md
# deserializer_queue

Parametrised serial-to-parallel converter with an integrated circular queue, the next generation of the team's separate deserializer and queue pair. Accepts one bit per qualified clock, assembles `DATA_WIDTH`-bit words in configurable bit order, and pushes completed words into a `DEPTH`-entry queue. Back-pressure on the serial side replaces silent overflow. Sits between the serial link front end and the word-consumer logic in the top level.

## Interface
- `DATA_WIDTH`, default 8: word width in bits; minimum 2.
- `DEPTH`, default 8: queue entries; power of two, minimum 2.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in bit `DATA_WIDTH-1`; 0 means it lands in bit 0.
- `clock`  in  1  single clock for all logic; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it clears all state immediately, and all state leaves reset on the rising edge after release.
- `data_in`  in  1  serial bit; sampled only when the bit is accepted.
- `write_in`  in  1  `data_in` is valid this cycle.
- `dequeue_in`  in  1  pop request for the head word.
- `clear_in`  in  1  synchronous flush of the queue, any partial word and the pending word.
- `status_out`  out  1  1 means serial bits are accepted; 0 means a stall.
- `data_out`  out  `DATA_WIDTH`  last popped word; registered.
- `data_valid_out`  out  1  one-cycle pulse when `data_out` is updated by a pop.
- `len_out`  out  `$clog2(DEPTH+1)`  current queue occupancy.
- `full_out`  out  1  `len_out == DEPTH`.
- `empty_out`  out  1  `len_out == 0`.

## Operation
- Bit accept: a bit is accepted on a rising edge when `write_in=1` and `status_out=1`. When `status_out=0`, `write_in` is ignored and the bit is lost; upstream must hold the bit.
- Shift register and counter:
  - Each accepted bit shifts in according to `MSB_FIRST`.
  - The bit counter runs 0..`DATA_WIDTH-1` and wraps to 0 on the last bit.
- Word completion (the last bit is accepted on this edge):
  - If `full_out=0` before the edge, the word is written to the tail on the same edge.
  - Otherwise the word goes to the pending register, and `pending` is set.
- Pending state:
  - `status_out = ~pending`.
  - The pending word is enqueued on the first edge where `full_out=0` was true before the edge, and `pending` clears on that edge.
  - A dequeue on the same edge does not free space for that edge; there is no bypass.
- Dequeue: on an edge with `dequeue_in=1` and `empty_out=0` before the edge:
  - `data_out` takes the head word.
  - `data_valid_out` is 1 for the following cycle.
  - The head pointer advances.
  - Dequeue while empty is ignored: no pulse, and `data_out` holds its value.
- Simultaneous enqueue and dequeue: both happen and `len_out` is unchanged. Pointers wrap modulo `DEPTH`.
- `clear_in` (priority over everything except reset):
  - Pointers, `len_out`, the bit counter and `pending` go to 0.
  - `data_out` holds its value and `data_valid_out` goes to 0.
  - Bits and pops in the same cycle are discarded.
- State machine: two states.
  - ACCEPT (`pending=0`) to STALL: the word completes while full.
  - STALL to ACCEPT: the pending word is enqueued, or `clear_in`.
- Reset values:
  - `status_out=1`, `data_out=0`, `data_valid_out=0`, `len_out=0`, `full_out=0`, `empty_out=1`.
  - Bit counter 0, `pending=0`.
  - Queue RAM contents are don't-care.

## Timing
- Latency from the last bit to queue entry: 0 extra cycles; `len_out` increments after the same edge.
- Latency from `dequeue_in` to data: `data_out` and `data_valid_out` are valid in the cycle after the accepting edge.
- `status_out`, `full_out` and `empty_out` are registered or derived from registered state only. There is no combinational path from any input to any output.
- Sustained throughput: one bit per cycle, one word per `DATA_WIDTH` cycles, when the consumer keeps the queue non-full.
- Asserting reset mid-word or mid-stall discards the partial word and the pending word.

## Test plan
Settings: `DATA_WIDTH=8`, `DEPTH=4`, `MSB_FIRST=1` unless stated.
- Basic word: shift 1,0,1,0,0,1,0,1 with `write_in=1` on 8 consecutive cycles, then pulse `dequeue_in`. Required: `len_out` 0→1 after bit 8, `data_out=8'hA5` with `data_valid_out` pulsed one cycle later, then `len_out=0` and `empty_out=1`.
- LSB-first: with `MSB_FIRST=0`, shift the same sequence. Required: `data_out=8'hA5` reversed, i.e. `8'hA5` becomes `8'hA5`'s reverse `8'hA5`→`8'hA5`; instead use bits 1,1,0,0,0,0,0,0 and require `data_out=8'h03` (`MSB_FIRST=1` gives `8'hC0`).
- Full and stall: fill 4 words `8'h01..8'h04`, then shift a 5th word `8'h05`. Required:
  - `full_out=1`, and `status_out` goes to 0 after the 5th word's last bit.
  - Further `write_in` bits are ignored.
  - One dequeue pops `8'h01`; on the next edge `8'h05` is enqueued, `status_out=1`, `len_out=4`.
  - Subsequent pops give 02, 03, 04, 05.
- Wrap and simultaneous operations: stream 10 words while dequeuing continuously after the first. Required: order preserved across pointer wrap, `len_out` stays at 1 during overlapped cycles, no stall.
- Edge cases: dequeue on empty gives no `data_valid_out` and `data_out` unchanged. Then load 3 bits, assert `clear_in`, then shift `8'hFF`. Required: `data_out=8'hFF`, with no residue from the 3 bits.
- Async reset: assert `reset=0` mid-stall with `len_out=4`. Required: immediately `len_out=0`, `empty_out=1`, `status_out=1`, `data_valid_out=0`, `data_out=0`, without waiting for a clock edge.
